fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch front end for the RISC-V core; the producer side of the control path.
- Holds the PC and issues word reads to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words in a small prefetch FIFO and presents them to decode as instr, op, funct3 and funct7b5.
- Consumes pc_src/target from the control/branch path to redirect, flushing stale work.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, PC after reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, minimum 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  word-aligned fetch address.
- imem_rsp_valid  input  1  response word valid; in order, at least 1 cycle after acceptance, no backpressure.
- imem_rsp_data  input  XLEN  response word.
- instr_valid  output  1  instruction available to decode.
- instr_ready  input  1  decode consumes instruction.
- instr  output  XLEN  instruction word at FIFO head.
- instr_pc  output  XLEN  address of that instruction.
- op  output  7  instr[6:0].
- funct3  output  3  instr[14:12].
- funct7b5  output  1  instr[30].
- pc_src  input  1  redirect request (taken branch/jump).
- pc_target  input  XLEN  redirect address; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - fetch_pc = RESET_PC, FIFO empty, outstanding = 0, discard = 0.
  - imem_req_valid = 0, instr_valid = 0.
  - instr, instr_pc, op, funct3 and funct7b5 read 0.
  - Reset mid-operation abandons all in-flight responses. The memory is reset alongside, so there is no discard carry-over.
- FSM states: RESET, RUN, DRAIN.
  - RESET lasts one cycle after rst_n rises, then moves to RUN.
  - RUN moves to DRAIN on pc_src while outstanding > 0 (excluding requests accepted that same cycle, which are added).
  - DRAIN returns to RUN when discard reaches 0.
- Issue:
  - imem_req_valid = 1 when state is RUN or DRAIN and (outstanding + fifo_count) < FIFO_DEPTH.
  - A request is accepted when valid & ready. On acceptance, fetch_pc += 4 and outstanding += 1.
  - Address wraps modulo 2^XLEN; 0xFFFF_FFFC is followed by 0x0000_0000.
  - imem_req_addr holds stable while valid and not ready.
- Response:
  - In RUN, or in DRAIN once discard = 0: rsp_valid pushes {data, pc} into the FIFO and outstanding -= 1.
  - In DRAIN with discard > 0: the response is dropped, discard -= 1 and outstanding -= 1.
  - The credit rule guarantees the FIFO never overflows; overflow is an assertion failure.
- Output:
  - instr_valid = FIFO not empty.
  - The head is combinationally decoded into op, funct3 and funct7b5.
  - Pop on instr_valid & instr_ready. Zero-cycle bypass from response to output is not required: a response is visible the cycle after rsp_valid.
- Redirect (pc_src = 1 at a clk edge):
  - fetch_pc = {pc_target[XLEN-1:2], 2'b00} and the FIFO is flushed.
  - discard = outstanding after this cycle's accept/response updates.
  - A request accepted in the redirect cycle is stale and counted in discard.
  - A response arriving in the redirect cycle is dropped.
  - A pop in the redirect cycle completes (decode consumed it); the remaining entries are flushed.
  - No request for the new PC is issued in the redirect cycle; the earliest new request is the next cycle.
  - pc_src during DRAIN re-targets fetch_pc, and discard is recomputed the same way.
- Latency: from pc_src, the first new-target instruction is valid at earliest cycle +3 (request +1, response +2, FIFO visible +3) with single-cycle memory.

Decomposition:
- riscv_pkg:
  - XLEN and RESET_PC defaults.
  - fetch_state_t enum {RESET, RUN, DRAIN}.
  - Opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL) for bench checking.
  - Field slice helpers for op, funct3 and funct7b5.
- Sub-module fetch_fifo: synchronous FIFO of {pc, instr}, FIFO_DEPTH entries, with push, pop, flush, count, full and empty. Flush has priority over push; pop and flush in the same cycle are legal.

Test Plan:
- Straight-line fetch: memory always ready, 1-cycle response, instr_ready=1 → addresses 0x0,0x4,0x8… each accepted once; instr_pc matches; decoding 0x00500093 gives op=0x13, funct3=0, funct7b5=0.
- Backpressure: instr_ready=0 for 10 cycles → at most FIFO_DEPTH requests are outstanding plus buffered, imem_req_valid drops, no word is lost; releasing ready resumes at the next sequential PC.
- Redirect with 2 in flight: pc_src=1 with pc_target=0x100 while outstanding=2 and 3-cycle memory latency → both stale responses are dropped; next instr_pc=0x100, then 0x104; instr_valid never shows stale PCs.
- Simultaneous events: pc_src in the same cycle as a pop, a request acceptance and a response → the popped instruction counts as consumed; the accepted request is discarded; the response is dropped; pc_target=0x203 fetches from 0x200.
- Wrap and reset: RESET_PC=0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; rst_n low mid-DRAIN for 1 cycle → all outputs are 0 next cycle and fetch restarts at RESET_PC with discard=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared defaults, fetch FSM encoding, opcodes and field helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic logic [6:0] instr_op(input logic [31:0] w);
        return w[6:0];
    endfunction

    function automatic logic [2:0] instr_funct3(input logic [31:0] w);
        return w[14:12];
    endfunction

    function automatic logic instr_funct7b5(input logic [31:0] w);
        return w[30];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous prefetch FIFO of {pc, instr}; flush beats push.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !empty_o;

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end: PC, credit-limited imem requests,
//            prefetch buffering, decode field extraction and redirect drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN       = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(RESET_PC_DEFAULT),
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7b5,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2*XLEN-1:0] fifo_rdata;

    logic          active;
    logic          redirect;
    logic          req_fire;
    logic          rsp_take;
    logic          rsp_drop;
    logic          rsp_push;
    logic          pop;
    logic [CW:0]   credit_used;
    logic          unused_tgt_lsbs;

    assign unused_tgt_lsbs = ^pc_target[1:0];

    assign active      = (state_q == RUN) || (state_q == DRAIN);
    assign redirect    = pc_src && active;
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};

    assign imem_req_valid = active && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses in a redirect cycle, or while stale words remain, are dropped.
    assign rsp_take = active && imem_rsp_valid;
    assign rsp_drop = rsp_take && (redirect || ((state_q == DRAIN) && (discard_q != '0)));
    assign rsp_push = rsp_take && !rsp_drop;

    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready;

    always_comb begin
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
        fetch_pc_d    = fetch_pc_q;
        discard_d     = discard_q;
        state_d       = state_q;

        if (redirect) begin
            fetch_pc_d = {pc_target[XLEN-1:2], 2'b00};
            discard_d  = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_drop) begin
                discard_d = discard_q - CW'(1);
            end
        end

        case (state_q)
            RESET:   state_d = RUN;
            default: state_d = (discard_d != '0) ? DRAIN : RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RESET;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_no_overflow: assert (!(rsp_push && !redirect && fifo_full && !pop));
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rsp_push),
        .wdata_i ({fetch_pc_of_rsp(), imem_rsp_data}),
        .pop_i   (pop),
        .flush_i (redirect),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Responses are in order, so each word's PC trails the fetch PC by the
    // number of requests still in flight (including this response).
    function automatic logic [XLEN-1:0] fetch_pc_of_rsp();
        return fetch_pc_q - XLEN'({outstanding_q, 2'b00});
    endfunction

    assign instr    = instr_valid ? fifo_rdata[XLEN-1:0]      : '0;
    assign instr_pc = instr_valid ? fifo_rdata[2*XLEN-1:XLEN] : '0;
    assign op       = instr_op(instr[31:0]);
    assign funct3   = instr_funct3(instr[31:0]);
    assign funct7b5 = instr_funct7b5(instr[31:0]);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Randomized bench for fetch_unit with in-order memory and a
//            sequential-PC reference stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int          XLEN       = 32;
    localparam logic [31:0] RESET_PC   = 32'hFFFF_FFF8;
    localparam int          FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (XLEN),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .op             (op),
        .funct3         (funct3),
        .funct7b5       (funct7b5),
        .pc_src         (pc_src),
        .pc_target      (pc_target)
    );

    int total = 0;
    int bad   = 0;

    // Memory model and reference stream state.
    int          cyc = 0;
    int          lat = 1;
    int          ready_pct = 100;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] exp_pc  = RESET_PC;
    logic [31:0] exp_req = RESET_PC;
    int          n_acc = 0;
    int          n_pops = 0;
    int          pops_since = 0;
    logic [31:0] first_pc = 32'h0;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // One clock: check visible outputs, advance the edge, update the model.
    task automatic cycle();
        logic        acc, pop, rsp, stall_next;
        logic [31:0] w, addr;
        acc  = (imem_req_valid === 1'b1) && imem_req_ready;
        pop  = (instr_valid === 1'b1) && instr_ready;
        rsp  = imem_rsp_valid;
        addr = imem_req_addr;
        stall_next = rst_n && (imem_req_valid === 1'b1) && !imem_req_ready && !pc_src;
        if (stall_prev) begin
            total++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== stall_addr) begin
                bad++;
                $display("FAIL req_hold: valid=%b addr=%h required valid=1 addr=%h",
                         imem_req_valid, imem_req_addr, stall_addr);
            end
        end
        if (instr_valid === 1'b1) begin
            w = mem_word(exp_pc);
            total++;
            if (instr_pc !== exp_pc || instr !== w || op !== w[6:0] ||
                funct3 !== w[14:12] || funct7b5 !== w[30]) begin
                bad++;
                $display("FAIL head: pc=%h instr=%h op=%h f3=%h f7b5=%b required pc=%h instr=%h",
                         instr_pc, instr, op, funct3, funct7b5, exp_pc, w);
            end
        end
        if (acc) begin
            total++;
            if (addr !== exp_req) begin
                bad++;
                $display("FAIL req_addr: addr=%h required %h", addr, exp_req);
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
            exp_pc     = RESET_PC;
            exp_req    = RESET_PC;
            pops_since = 0;
            stall_prev = 1'b0;
        end else begin
            if (pop) begin
                if (pops_since == 0) first_pc = exp_pc;
                pops_since++;
                n_pops++;
                exp_pc = exp_pc + 32'd4;
            end
            if (rsp) begin
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (acc) begin
                q_addr.push_back(addr);
                q_due.push_back(cyc + lat);
                n_acc++;
                exp_req = exp_req + 32'd4;
            end
            stall_prev = stall_next;
            stall_addr = addr;
            if (pc_src) begin
                exp_pc     = {pc_target[31:2], 2'b00};
                exp_req    = {pc_target[31:2], 2'b00};
                pops_since = 0;
            end
        end
        cyc++;
        #1;
        imem_req_ready = (int'($urandom_range(99)) < ready_pct);
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(q_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        total++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
            instr_pc !== 32'h0 || op !== 7'h0 || funct3 !== 3'h0 || funct7b5 !== 1'b0) begin
            bad++;
            $display("FAIL %s: req_valid=%b instr_valid=%b instr=%h pc=%h op=%h f3=%h f7b5=%b required all 0",
                     tag, imem_req_valid, instr_valid, instr, instr_pc, op, funct3, funct7b5);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        check_zero_outputs("reset_outputs");
        rst_n = 1'b1;
    endtask

    task automatic test_straight();
        bit seen = 0;
        lat = 1; ready_pct = 100; instr_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (!seen && instr_valid === 1'b1 && instr_pc === 32'h0) begin
                seen = 1;
                total++;
                if (op !== OP_I || funct3 !== 3'd0 || funct7b5 !== 1'b0) begin
                    bad++;
                    $display("FAIL decode_addi: op=%h f3=%h f7b5=%b required op=13 f3=0 f7b5=0",
                             op, funct3, funct7b5);
                end
            end
            cycle();
        end
        total++;
        if (!seen || n_pops < 10) begin
            bad++;
            $display("FAIL straight_progress: seen_pc0=%0d pops=%0d required 1 and >=10", seen, n_pops);
        end
    endtask

    task automatic test_backpressure();
        int acc0, pops0;
        instr_ready = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 10; i++) cycle();
        total++;
        if (n_acc - acc0 > FIFO_DEPTH || imem_req_valid !== 1'b0 || instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL backpressure: accepts=%0d req_valid=%b instr_valid=%b required <=%0d, 0, 1",
                     n_acc - acc0, imem_req_valid, instr_valid, FIFO_DEPTH);
        end
        instr_ready = 1'b1;
        pops0 = n_pops;
        for (int i = 0; i < 20; i++) cycle();
        total++;
        if (n_pops - pops0 < 8) begin
            bad++;
            $display("FAIL backpressure_resume: pops=%0d required >=8", n_pops - pops0);
        end
    endtask

    task automatic test_latency();
        logic [31:0] tgt;
        lat = 1; ready_pct = 100; instr_ready = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        tgt = $urandom & 32'hFFFF_FFFC;
        pc_src = 1'b1; pc_target = tgt;
        cycle();
        pc_src = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            total++;
            if ((k < 3 && instr_valid !== 1'b0) ||
                (k == 3 && (instr_valid !== 1'b1 || instr_pc !== tgt))) begin
                bad++;
                $display("FAIL redirect_latency_c%0d: valid=%b pc=%h required valid=%0d pc=%h",
                         k, instr_valid, instr_pc, k == 3, tgt);
            end
            if (k < 3) cycle();
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
    endtask

    task automatic redirect_when(input int want_q, input logic [31:0] tgt, input string tag);
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (q_addr.size() == want_q) hit = 1;
            else cycle();
        end
        if (!hit) begin
            total++; bad++;
            $display("FAIL %s_setup: in-flight=%0d required %0d", tag, q_addr.size(), want_q);
        end
        pc_src = 1'b1; pc_target = tgt;
        cycle();
        pc_src = 1'b0;
    endtask

    task automatic test_redirect_inflight();
        lat = 3; ready_pct = 100; instr_ready = 1'b1;
        redirect_when(2, 32'h100, "redirect_inflight");
        total++;
        if (instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL redirect_flush: instr_valid=%b required 0", instr_valid);
        end
        for (int i = 0; i < 25; i++) cycle();
        total++;
        if (first_pc !== 32'h100 || pops_since < 2) begin
            bad++;
            $display("FAIL redirect_target: first_pc=%h pops=%0d required 100 and >=2", first_pc, pops_since);
        end
    endtask

    task automatic test_simultaneous();
        bit hit = 0;
        lat = 1; ready_pct = 100; instr_ready = 1'b1;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (imem_req_valid === 1'b1 && imem_req_ready && imem_rsp_valid && instr_valid === 1'b1)
                hit = 1;
            else
                cycle();
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL simul_setup: no cycle with accept+response+pop, required one");
        end
        pc_src = 1'b1; pc_target = 32'h203;
        cycle();
        pc_src = 1'b0;
        total++;
        if (instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL simul_flush: instr_valid=%b required 0", instr_valid);
        end
        for (int i = 0; i < 15; i++) cycle();
        total++;
        if (first_pc !== 32'h200 || pops_since < 2) begin
            bad++;
            $display("FAIL simul_target: first_pc=%h pops=%0d required 200 and >=2", first_pc, pops_since);
        end
    endtask

    task automatic test_random();
        int pops0 = n_pops;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = 1 + int'($urandom_range(2));
            ready_pct   = 60;
            instr_ready = ($urandom_range(99) < 70);
            pc_src      = ($urandom_range(99) < 4);
            pc_target   = $urandom;
            cycle();
        end
        pc_src = 1'b0; instr_ready = 1'b1; ready_pct = 100;
        for (int i = 0; i < 10; i++) cycle();
        total++;
        if (n_pops - pops0 < 50) begin
            bad++;
            $display("FAIL random_progress: pops=%0d required >=50", n_pops - pops0);
        end
    endtask

    task automatic test_reset_mid_drain();
        lat = 3; ready_pct = 100; instr_ready = 1'b1;
        redirect_when(2, 32'h400, "drain_reset");
        rst_n = 1'b0;
        cycle();
        check_zero_outputs("drain_reset_outputs");
        rst_n = 1'b1;
        lat = 1;
        for (int i = 0; i < 25; i++) cycle();
        total++;
        if (first_pc !== RESET_PC || pops_since < 3) begin
            bad++;
            $display("FAIL drain_reset_restart: first_pc=%h pops=%0d required %h and >=3",
                     first_pc, pops_since, RESET_PC);
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_backpressure();
        test_latency();
        test_redirect_inflight();
        test_simultaneous();
        test_random();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
